// File: rtl/gray_counter_param.sv
// Parametrised up/down counter with registered binary and Gray views.
// Gray view is registered from the next binary value so both views update together.
module gray_counter_param #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             wrap_nxt;

  // Gray-to-binary is the prefix XOR of the Gray word from the MSB down.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  assign tc = up_dn ? (&bin_out) : ~(|bin_out);

  // Next count: load beats enable; a step at the limit either wraps or is held.
  always_comb begin
    bin_nxt  = bin_out;
    wrap_nxt = 1'b0;
    if (load) begin
      bin_nxt = load_is_gray ? gray_to_bin(load_val) : load_val;
    end else if (en) begin
      wrap_nxt = tc;
      if (!(SATURATE && tc)) begin
        bin_nxt = up_dn ? (bin_out + WIDTH'(1)) : (bin_out - WIDTH'(1));
      end
    end
    gray_nxt = bin_nxt ^ (bin_nxt >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out  <= RST_BIN;
      gray_out <= RST_GRAY;
      wrap     <= 1'b0;
    end else begin
      bin_out  <= bin_nxt;
      gray_out <= gray_nxt;
      wrap     <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed bench for gray_counter_param: a wrapping instance and a saturating instance.
module tb_gray_counter_param;

  localparam int unsigned W = 4;

  logic clk;
  logic rst_n;

  logic         en_w, up_w, ld_w, lg_w;
  logic [W-1:0] lv_w, bin_w, gray_w;
  logic         tc_w, wrap_w;

  logic         en_s, up_s, ld_s, lg_s;
  logic [W-1:0] lv_s, bin_s, gray_s;
  logic         tc_s, wrap_s;

  int n_cmp;
  int n_err;

  gray_counter_param #(.WIDTH(W), .RESET_VAL(0), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(en_w), .up_dn(up_w), .load(ld_w),
    .load_is_gray(lg_w), .load_val(lv_w), .bin_out(bin_w), .gray_out(gray_w),
    .tc(tc_w), .wrap(wrap_w)
  );

  gray_counter_param #(.WIDTH(W), .RESET_VAL(0), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en_s), .up_dn(up_s), .load(ld_s),
    .load_is_gray(lg_s), .load_val(lv_s), .bin_out(bin_s), .gray_out(gray_s),
    .tc(tc_s), .wrap(wrap_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gray sequence after each of 16 up steps from zero.
  logic [W-1:0] gray_seq [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                  4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  initial begin
    logic [W-1:0] prev_gray;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    {en_w, up_w, ld_w, lg_w} = '0; lv_w = '0;
    {en_s, up_s, ld_s, lg_s} = '0; lv_s = '0;
    #12;
    chk("rst_bin", 32'(bin_w), 32'h0);
    chk("rst_gray", 32'(gray_w), 32'h0);
    chk("rst_wrap", 32'(wrap_w), 32'h0);
    chk("rst_sat_bin", 32'(bin_s), 32'h0);
    rst_n = 1'b1;
    #4;

    // Load 9, then pulse reset between edges.
    ld_w = 1'b1; lv_w = 4'h9;
    tick();
    chk("load9_bin", 32'(bin_w), 32'h9);
    chk("load9_gray", 32'(gray_w), 32'hD);
    ld_w = 1'b0; en_w = 1'b1; up_w = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_bin", 32'(bin_w), 32'h0);
    chk("midrst_gray", 32'(gray_w), 32'h0);
    chk("midrst_wrap", 32'(wrap_w), 32'h0);
    #1 rst_n = 1'b1;

    // Full up sequence with wrap on the 16th step.
    prev_gray = gray_w;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("up%0d_bin", k), 32'(bin_w), 32'(k % 16));
      chk($sformatf("up%0d_gray", k), 32'(gray_w), 32'(gray_seq[k-1]));
      chk($sformatf("up%0d_onebit", k), 32'($countones(gray_w ^ prev_gray)), 32'd1);
      chk($sformatf("up%0d_wrap", k), 32'(wrap_w), (k == 16) ? 32'd1 : 32'd0);
      prev_gray = gray_w;
    end

    // Down wrap from zero.
    up_w = 1'b0;
    #1;
    chk("dn_tc_before", 32'(tc_w), 32'h1);
    tick();
    chk("dnwrap_bin", 32'(bin_w), 32'hF);
    chk("dnwrap_gray", 32'(gray_w), 32'h8);
    chk("dnwrap_wrap", 32'(wrap_w), 32'h1);
    en_w = 1'b0;
    tick();
    chk("hold_bin", 32'(bin_w), 32'hF);
    chk("hold_wrap", 32'(wrap_w), 32'h0);

    // Gray load then one up step.
    ld_w = 1'b1; lg_w = 1'b1; lv_w = 4'hD;
    tick();
    chk("gload_bin", 32'(bin_w), 32'h9);
    chk("gload_gray", 32'(gray_w), 32'hD);
    ld_w = 1'b0; lg_w = 1'b0; en_w = 1'b1; up_w = 1'b1;
    tick();
    chk("gstep_bin", 32'(bin_w), 32'hA);
    chk("gstep_gray", 32'(gray_w), 32'hF);

    // Priority: load at all-ones with en high must not wrap.
    en_w = 1'b0; ld_w = 1'b1; lv_w = 4'hF;
    tick();
    en_w = 1'b1; up_w = 1'b1; lv_w = 4'h5;
    tick();
    chk("prio_bin", 32'(bin_w), 32'h5);
    chk("prio_gray", 32'(gray_w), 32'h7);
    chk("prio_wrap", 32'(wrap_w), 32'h0);
    {en_w, ld_w} = '0;

    // Saturating instance: hold at all-ones.
    ld_s = 1'b1; lv_s = 4'hE;
    tick();
    chk("sload_bin", 32'(bin_s), 32'hE);
    ld_s = 1'b0; en_s = 1'b1; up_s = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("sat%0d_bin", k), 32'(bin_s), 32'hF);
      chk($sformatf("sat%0d_gray", k), 32'(gray_s), 32'h8);
      chk($sformatf("sat%0d_wrap", k), 32'(wrap_s), (k == 1) ? 32'd0 : 32'd1);
    end
    chk("sat_tc_up", 32'(tc_s), 32'h1);
    up_s = 1'b0;
    #1;
    chk("sat_tc_dn", 32'(tc_s), 32'h0);
    tick();
    chk("sat_dn_bin", 32'(bin_s), 32'hE);
    chk("sat_dn_wrap", 32'(wrap_s), 32'h0);

    // Saturating instance: hold at zero.
    en_s = 1'b0; ld_s = 1'b1; lv_s = 4'h0;
    tick();
    ld_s = 1'b0; en_s = 1'b1; up_s = 1'b0;
    tick();
    chk("satlo_bin", 32'(bin_s), 32'h0);
    chk("satlo_wrap", 32'(wrap_s), 32'h1);
    en_s = 1'b0;
    tick();
    chk("satlo_hold_wrap", 32'(wrap_s), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
- Parametrised up/down counter that holds its state in binary and presents registered binary and Gray-code views of the count.
- Successor to the fixed 4-bit combinational binary-to-Gray converter. Adds a clock, a configurable width, loading from either binary or Gray, direction control, and optional saturation instead of wrap-around.
- Intended uses: Gray pointer generation for clock-domain-crossing FIFOs, and Gray-sequenced position/state encoders.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- RESET_VAL, 0, binary count value applied on reset; must fit in WIDTH bits.
- SATURATE, 0, selects limit behaviour. 0 = wrap at the limits. 1 = hold at the limit (all-ones when counting up, zero when counting down).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  active-low asynchronous reset.
- en  input  1  count enable; one step per clock edge while high.
- up_dn  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe; takes priority over en.
- load_is_gray  input  1  1 = load_val is Gray code, 0 = load_val is binary.
- load_val  input  WIDTH  value to load.
- bin_out  output  WIDTH  registered binary count.
- gray_out  output  WIDTH  registered Gray count; always equals bin_out ^ (bin_out >> 1).
- tc  output  1  combinational terminal-count flag. High when bin_out is all-ones and up_dn=1, or when bin_out is 0 and up_dn=0.
- wrap  output  1  registered one-cycle pulse marking a wrap event, or a saturation-blocked step when SATURATE=1.

Behaviour:
- Asynchronous reset, asserted while rst_n=0:
  - bin_out = RESET_VAL
  - gray_out = RESET_VAL ^ (RESET_VAL >> 1)
  - wrap = 0
- Reset deassertion is synchronised by the system. The first counting edge is the first rising clk edge with rst_n=1.
- Reset mid-operation: all state returns to the reset values immediately, with no dependency on clk. Any load or step in progress is discarded.
- Priority on each rising edge: load > en > hold.
- Load:
  - When load_is_gray=0, the next count is load_val.
  - When load_is_gray=1, the next count is the Gray-to-binary conversion of load_val: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i] for i = W-2 down to 0.
  - Load ignores en and up_dn, and forces wrap=0 on that edge.
- Step (en=1, load=0):
  - Next count is bin_out + 1 when up_dn=1, or bin_out - 1 when up_dn=0, computed modulo 2^WIDTH.
- Wrap-around (SATURATE=0):
  - Stepping up from all-ones gives 0; stepping down from 0 gives all-ones.
  - On that same edge wrap is registered to 1. It returns to 0 on the next edge unless another wrap occurs.
- Saturation (SATURATE=1):
  - A step requested while tc=1 leaves the count unchanged and registers wrap=1 for one cycle.
  - Continuous en against the limit holds wrap high on every such edge.
- Hold (en=0, load=0): count unchanged; wrap registered to 0.
- Latency:
  - bin_out and gray_out update together on the same edge as the load or step. No one-cycle skew between the two views is permitted.
  - gray_out is computed from the next binary value and registered; it is never derived combinationally from bin_out.
- Gray invariant: each single step changes exactly one bit of gray_out, including the wrap step. A load may change any number of bits.
- Direction change: up_dn may change on any cycle. It takes effect on the same edge, and tc follows it combinationally.
- Load and en both high: load wins and en is ignored for that cycle.
- Width rules: all arithmetic is WIDTH bits unsigned. No carry-out port; wrap is the only overflow indication.

Test Plan:
- Reset (WIDTH=4, RESET_VAL=0): pulse rst_n low mid-count with count=9 -> immediately bin_out=0000, gray_out=0000, wrap=0, with no clock edge required.
- Full up sequence (WIDTH=4, SATURATE=0): hold en=1, up_dn=1 for 16 edges from 0 -> gray_out steps 0000,0001,0011,0010,0110,...,1000,0000. Exactly one bit changes per step. wrap=1 only in the cycle after 1111->0000.
- Down wrap: from 0 with en=1, up_dn=0 -> bin_out=1111, gray_out=1000, wrap=1 for one cycle. tc=1 before that edge.
- Gray load: load=1, load_is_gray=1, load_val=1101 -> bin_out=1001, gray_out=1101. The next up step gives bin_out=1010, gray_out=1111.
- Saturate (SATURATE=1): load binary 1110, then en=1, up_dn=1 for 3 edges -> bin_out 1111, 1111, 1111. wrap is 0, then 1, then 1. Setting up_dn=0 drops tc and the next step gives 1110.
- Priority: load=1 and en=1 with load_val=0101 binary -> bin_out=0101, wrap=0. The step is ignored on that edge.
